// File: rtl/scan_integ_pkg.sv
// Shared types and helpers for the scan TDO integrity checker: FSM state,
// default CRC constants, and a width-agnostic serial CRC step.
`timescale 1ns/1ps
package scan_integ_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAG  = 2'd2
    } state_t;

    localparam logic [31:0] DEF_CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] DEF_CRC_INIT = 32'hFFFFFFFF;

    // CRC words are carried left-justified in this width so one step
    // function serves every CRC_W up to CRC_MAX_W.
    localparam int CRC_MAX_W = 64;
    typedef logic [CRC_MAX_W-1:0] crc_word_t;

    // One MSB-first, non-reflected CRC step on left-justified crc/poly.
    function automatic crc_word_t crc_step(input crc_word_t crc, input logic din,
                                           input crc_word_t poly);
        logic fb;
        fb = crc[CRC_MAX_W-1] ^ din;
        return (crc << 1) ^ (fb ? poly : '0);
    endfunction

    // Counter must index both the payload and the tag.
    function automatic int bit_cnt_width(input int frame_bits, input int crc_w);
        int m;
        m = (frame_bits > crc_w) ? frame_bits : crc_w;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/scan_tdo_integrity_checker_if.sv
// Stream and status bundle between the TDO source/test controller (master)
// and the integrity checker (slave).
`timescale 1ns/1ps
interface scan_tdo_integrity_checker_if #(
    parameter int CRC_W = 32,
    parameter int CNT_W = 16
);
    logic             shift_en;
    logic             tdo_in;
    logic             frame_start;
    logic             busy;
    logic             frame_done;
    logic             frame_ok;
    logic             frame_err;
    logic             frame_abort;
    logic [CRC_W-1:0] crc_out;
    logic [CNT_W-1:0] frame_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output shift_en, tdo_in, frame_start,
        input  busy, frame_done, frame_ok, frame_err, frame_abort,
        input  crc_out, frame_count, err_count
    );

    modport slave (
        input  shift_en, tdo_in, frame_start,
        output busy, frame_done, frame_ok, frame_err, frame_abort,
        output crc_out, frame_count, err_count
    );
endinterface

// File: rtl/scan_crc_lfsr.sv
// Serial CRC register: load reseeds with INIT, en folds in one bit; when both
// are set the bit is folded into the fresh seed.
`timescale 1ns/1ps
module scan_crc_lfsr
    import scan_integ_pkg::*;
#(
    parameter int             W    = 32,
    parameter logic [W-1:0]   POLY = W'(DEF_CRC_POLY),
    parameter logic [W-1:0]   INIT = W'(DEF_CRC_INIT)
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         i_load,
    input  logic         i_en,
    input  logic         i_bit,
    output logic [W-1:0] o_crc
);
    localparam int        SH      = CRC_MAX_W - W;
    localparam crc_word_t POLY_LJ = CRC_MAX_W'(POLY) << SH;

    logic [W-1:0] r_crc;
    logic [W-1:0] w_base;
    crc_word_t    w_step;

    assign w_base = i_load ? INIT : r_crc;
    assign w_step = crc_step(CRC_MAX_W'(w_base) << SH, i_bit, POLY_LJ);

    always_ff @(posedge clk) begin
        if (srst) begin
            r_crc <= INIT;
        end else if (i_en) begin
            r_crc <= W'(w_step >> SH);
        end else if (i_load) begin
            r_crc <= INIT;
        end
    end

    assign o_crc = r_crc;
endmodule

// File: rtl/scan_tdo_integrity_checker.sv
// Frames the serial TDO stream into payload + tag, checks the tag against a
// recomputed CRC and keeps frame/error statistics.
// Optional macro SCAN_INTEG_ERR_CNT_EN enables the saturating error counter.
`timescale 1ns/1ps
module scan_tdo_integrity_checker
    import scan_integ_pkg::*;
#(
    parameter int               FRAME_BITS = 128,
    parameter int               CRC_W      = 32,
    parameter logic [CRC_W-1:0] CRC_POLY   = CRC_W'(DEF_CRC_POLY),
    parameter logic [CRC_W-1:0] CRC_INIT   = CRC_W'(DEF_CRC_INIT),
    parameter int               CNT_W      = 16
) (
    input  logic                        tck,
    input  logic                        reset,
    scan_tdo_integrity_checker_if.slave bus
);
    localparam int             BC_W      = bit_cnt_width(FRAME_BITS, CRC_W);
    localparam logic [BC_W-1:0] LAST_DATA = BC_W'(FRAME_BITS - 1);
    localparam logic [BC_W-1:0] LAST_TAG  = BC_W'(CRC_W - 1);

    state_t           r_state;
    logic [BC_W-1:0]  r_bit_cnt;
    logic [CRC_W-2:0] r_tag_sr;
    logic             r_frame_done;
    logic             r_frame_ok;
    logic             r_frame_err;
    logic             r_frame_abort;
    logic [CRC_W-1:0] r_crc_out;
    logic [CNT_W-1:0] r_frame_count;

    logic             w_last_tag;
    logic             w_match;
    logic             w_crc_load;
    logic             w_crc_en;
    logic [CRC_W-1:0] w_crc;

    assign w_last_tag = (r_state == TAG) && bus.shift_en && (r_bit_cnt == LAST_TAG);
    assign w_match    = ({r_tag_sr, bus.tdo_in} == w_crc);

    // The final tag bit is never folded in, even when frame_start rides with it.
    assign w_crc_load = bus.frame_start || w_last_tag;
    assign w_crc_en   = bus.shift_en && !w_last_tag &&
                        (bus.frame_start || (r_state == DATA));

    scan_crc_lfsr #(
        .W    (CRC_W),
        .POLY (CRC_POLY),
        .INIT (CRC_INIT)
    ) u_crc (
        .clk    (tck),
        .srst   (reset),
        .i_load (w_crc_load),
        .i_en   (w_crc_en),
        .i_bit  (bus.tdo_in),
        .o_crc  (w_crc)
    );

    always_ff @(posedge tck) begin
        if (reset) begin
            r_state       <= IDLE;
            r_bit_cnt     <= '0;
            r_tag_sr      <= '0;
            r_frame_done  <= 1'b0;
            r_frame_ok    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_abort <= 1'b0;
            r_crc_out     <= '0;
            r_frame_count <= '0;
        end else begin
            r_frame_done  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_abort <= 1'b0;
            if (w_last_tag) begin
                r_frame_done  <= 1'b1;
                r_frame_ok    <= w_match;
                r_frame_err   <= !w_match;
                r_crc_out     <= w_crc;
                r_frame_count <= r_frame_count + CNT_W'(1);
                r_state       <= DATA;
                r_bit_cnt     <= '0;
            end else if (bus.frame_start) begin
                r_frame_abort <= (r_state != IDLE);
                r_state       <= DATA;
                r_bit_cnt     <= bus.shift_en ? BC_W'(1) : '0;
            end else if (bus.shift_en) begin
                unique case (r_state)
                    DATA: begin
                        if (r_bit_cnt == LAST_DATA) begin
                            r_state   <= TAG;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BC_W'(1);
                        end
                    end
                    TAG: begin
                        r_tag_sr  <= {r_tag_sr[CRC_W-3:0], bus.tdo_in};
                        r_bit_cnt <= r_bit_cnt + BC_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SCAN_INTEG_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_count;

    always_ff @(posedge tck) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_last_tag && !w_match && (r_err_count != '1)) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign bus.err_count = r_err_count;
`else
    assign bus.err_count = '0;
`endif

    assign bus.busy        = (r_state != IDLE);
    assign bus.frame_done  = r_frame_done;
    assign bus.frame_ok    = r_frame_ok;
    assign bus.frame_err   = r_frame_err;
    assign bus.frame_abort = r_frame_abort;
    assign bus.crc_out     = r_crc_out;
    assign bus.frame_count = r_frame_count;
endmodule

// File: tb/tb_scan_tdo_integrity_checker.sv
// Bench for scan_tdo_integrity_checker: two instances (CRC_INIT=0 and defaults)
// share one stream; a scoreboard queue per instance holds expected frame results.
`timescale 1ns/1ps
module tb_scan_tdo_integrity_checker;
    localparam logic [31:0] POLY = 32'h04C11DB7;
`ifdef SCAN_INTEG_ERR_CNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    typedef struct {
        logic        ok;
        logic [31:0] crc;
        logic [15:0] cnt;
        logic [15:0] err;
        int          cyc;
    } exp_t;

    logic tck = 1'b0;
    logic reset, shift_en, tdo_in, frame_start;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   aborts0 = 0;
    int   aborts1 = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [15:0] m_cnt0, m_cnt1, m_err0, m_err1;

    always #5 tck = ~tck;
    always @(posedge tck) cyc++;

    scan_tdo_integrity_checker_if #(.CRC_W(32), .CNT_W(16)) if0 ();
    scan_tdo_integrity_checker_if #(.CRC_W(32), .CNT_W(16)) if1 ();

    assign if0.shift_en    = shift_en;
    assign if0.tdo_in      = tdo_in;
    assign if0.frame_start = frame_start;
    assign if1.shift_en    = shift_en;
    assign if1.tdo_in      = tdo_in;
    assign if1.frame_start = frame_start;

    scan_tdo_integrity_checker #(.CRC_INIT(32'h0)) u_dut0 (
        .tck(tck), .reset(reset), .bus(if0.slave)
    );
    scan_tdo_integrity_checker u_dut1 (
        .tck(tck), .reset(reset), .bus(if1.slave)
    );

    function automatic logic [31:0] model_crc(input logic [31:0] init, input logic [127:0] pl);
        logic [31:0] c;
        c = init;
        for (int i = 127; i >= 0; i--) begin
            if (c[31] ^ pl[i]) c = (c << 1) ^ POLY;
            else               c = c << 1;
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string p, input logic busy, input logic done, input logic ok,
                            input logic err, input logic abt, input logic [31:0] crc,
                            input logic [15:0] fcnt, input logic [15:0] ecnt);
        chk({p, "_busy"}, 64'(busy), 64'd0);
        chk({p, "_done"}, 64'(done), 64'd0);
        chk({p, "_ok"},   64'(ok),   64'd0);
        chk({p, "_err"},  64'(err),  64'd0);
        chk({p, "_abort"},64'(abt),  64'd0);
        chk({p, "_crc"},  64'(crc),  64'd0);
        chk({p, "_fcnt"}, 64'(fcnt), 64'd0);
        chk({p, "_ecnt"}, 64'(ecnt), 64'd0);
    endtask

    task automatic check_frame(input int id, input logic ok, input logic err,
                               input logic [31:0] crc, input logic [15:0] fcnt,
                               input logic [15:0] ecnt);
        exp_t  e;
        string p;
        p = $sformatf("d%0d", id);
        if ((id == 0 ? q0.size() : q1.size()) == 0) begin
            tests++;
            assert (0) else begin
                fails++;
                $error("FAIL %s_unexpected_done observed=1 expected=0 at cyc %0d", p, cyc);
            end
        end else begin
            e = (id == 0) ? q0.pop_front() : q1.pop_front();
            chk({p, "_frame_ok"},  64'(ok),   64'(e.ok));
            chk({p, "_frame_err"}, 64'(err),  64'(!e.ok));
            chk({p, "_crc_out"},   64'(crc),  64'(e.crc));
            chk({p, "_frame_cnt"}, 64'(fcnt), 64'(e.cnt));
            chk({p, "_err_cnt"},   64'(ecnt), 64'(e.err));
            chk({p, "_latency"},   64'(cyc),  64'(e.cyc));
        end
    endtask

    always @(negedge tck) begin
        if (if0.frame_done === 1'b1)
            check_frame(0, if0.frame_ok, if0.frame_err, if0.crc_out, if0.frame_count, if0.err_count);
        if (if1.frame_done === 1'b1)
            check_frame(1, if1.frame_ok, if1.frame_err, if1.crc_out, if1.frame_count, if1.err_count);
        if (if0.frame_abort === 1'b1) aborts0++;
        if (if1.frame_abort === 1'b1) aborts1++;
    end

    task automatic push_expected(input logic [127:0] pl, input logic [31:0] tag, input int at);
        exp_t e;
        e.cyc = at;
        e.crc = model_crc(32'h0, pl);
        e.ok  = (e.crc == tag);
        m_cnt0 = m_cnt0 + 16'd1;
        if (!e.ok && ERRCNT && m_err0 != 16'hFFFF) m_err0 = m_err0 + 16'd1;
        e.cnt = m_cnt0;
        e.err = m_err0;
        q0.push_back(e);
        e.crc = model_crc(32'hFFFFFFFF, pl);
        e.ok  = (e.crc == tag);
        m_cnt1 = m_cnt1 + 16'd1;
        if (!e.ok && ERRCNT && m_err1 != 16'hFFFF) m_err1 = m_err1 + 16'd1;
        e.cnt = m_cnt1;
        e.err = m_err1;
        q1.push_back(e);
    endtask

    // Called aligned at posedge+1; returns aligned at posedge+1 after the sampling edge.
    task automatic send_bit(input logic b, input logic fs, input int gap);
        repeat (gap) begin
            @(posedge tck); #1;
        end
        shift_en = 1'b1; tdo_in = b; frame_start = fs;
        @(posedge tck); #1;
        last_cyc = cyc;
        shift_en = 1'b0; frame_start = 1'b0;
    endtask

    // mode 0: no frame_start, 1: frame_start alone, 2: frame_start with payload bit 0
    task automatic send_frame(input logic [127:0] pl, input logic [31:0] tag, input int mode,
                              input int gapmax, input logic fs_last);
        if (mode == 1) begin
            frame_start = 1'b1;
            @(posedge tck); #1;
            frame_start = 1'b0;
        end
        for (int i = 127; i >= 0; i--)
            send_bit(pl[i], (mode == 2) && (i == 127), $urandom_range(0, gapmax));
        for (int i = 31; i >= 0; i--)
            send_bit(tag[i], fs_last && (i == 0), $urandom_range(0, gapmax));
        push_expected(pl, tag, last_cyc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pl;
        logic [31:0]  tg;
        reset = 1'b1; shift_en = 1'b0; tdo_in = 1'b0; frame_start = 1'b0;
        m_cnt0 = '0; m_cnt1 = '0; m_err0 = '0; m_err1 = '0;
        repeat (3) @(posedge tck);
        @(negedge tck);
        chk_zero("rst_d0", if0.busy, if0.frame_done, if0.frame_ok, if0.frame_err,
                 if0.frame_abort, if0.crc_out, if0.frame_count, if0.err_count);
        chk_zero("rst_d1", if1.busy, if1.frame_done, if1.frame_ok, if1.frame_err,
                 if1.frame_abort, if1.crc_out, if1.frame_count, if1.err_count);
        @(posedge tck); #1;
        reset = 1'b0;
        repeat (2) begin @(posedge tck); #1; end

        // T1: all-zero payload and tag
        send_frame(128'h0, 32'h0, 1, 0, 1'b0);
        repeat (2) begin @(posedge tck); #1; end
        // T2: single 1 in the final payload bit
        send_frame(128'h1, 32'h04C11DB7, 0, 0, 1'b0);
        // T3: alternating payload, one tag bit flipped
        pl = {16{8'hAA}};
        send_frame(pl, model_crc(32'hFFFFFFFF, pl) ^ 32'h0001_0000, 0, 0, 1'b0);

        // T4: abort after 64 payload bits, then a clean frame
        for (int i = 0; i < 64; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 0);
        frame_start = 1'b1;
        @(posedge tck);
        @(negedge tck);
        frame_start = 1'b0;
        chk("t4_abort_d0", 64'(if0.frame_abort), 64'd1);
        chk("t4_abort_d1", 64'(if1.frame_abort), 64'd1);
        chk("t4_fcnt_d0",  64'(if0.frame_count), 64'(m_cnt0));
        chk("t4_fcnt_d1",  64'(if1.frame_count), 64'(m_cnt1));
        chk("t4_busy_d1",  64'(if1.busy), 64'd1);
        @(posedge tck); #1;
        pl = {$urandom, $urandom, $urandom, $urandom};
        send_frame(pl, model_crc(32'hFFFFFFFF, pl), 0, 0, 1'b0);

        // T5: three back-to-back frames with random gaps; last tag bit carries frame_start
        pl = {$urandom, $urandom, $urandom, $urandom};
        send_frame(pl, model_crc(32'hFFFFFFFF, pl), 0, 3, 1'b0);
        pl = {$urandom, $urandom, $urandom, $urandom};
        send_frame(pl, model_crc(32'h0, pl), 0, 3, 1'b0);
        pl = {$urandom, $urandom, $urandom, $urandom};
        tg = $urandom;
        send_frame(pl, tg, 0, 3, 1'b1);
        @(negedge tck);
        chk("t5_busy_d0", 64'(if0.busy), 64'd1);
        chk("t5_no_abort_d0", 64'(aborts0), 64'd1);
        chk("t5_no_abort_d1", 64'(aborts1), 64'd1);
        @(posedge tck); #1;

        // T6: reset at payload bit 100, then stray bits are ignored
        for (int i = 0; i < 100; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 0);
        reset = 1'b1; shift_en = 1'b1; tdo_in = 1'b1;
        @(posedge tck); #1;
        shift_en = 1'b0;
        @(negedge tck);
        chk_zero("t6_d0", if0.busy, if0.frame_done, if0.frame_ok, if0.frame_err,
                 if0.frame_abort, if0.crc_out, if0.frame_count, if0.err_count);
        chk_zero("t6_d1", if1.busy, if1.frame_done, if1.frame_ok, if1.frame_err,
                 if1.frame_abort, if1.crc_out, if1.frame_count, if1.err_count);
        m_cnt0 = '0; m_cnt1 = '0; m_err0 = '0; m_err1 = '0;
        @(posedge tck); #1;
        reset = 1'b0;
        for (int i = 0; i < 200; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 0);
        @(negedge tck);
        chk("t6_idle_busy_d0", 64'(if0.busy), 64'd0);
        chk("t6_idle_fcnt_d1", 64'(if1.frame_count), 64'd0);
        @(posedge tck); #1;

        // Fresh frame from IDLE with bit 0 riding on frame_start
        pl = {$urandom, $urandom, $urandom, $urandom};
        send_frame(pl, model_crc(32'hFFFFFFFF, pl), 2, 1, 1'b0);
        repeat (3) begin @(posedge tck); #1; end
        @(negedge tck);
        chk("end_q0_empty", 64'(q0.size()), 64'd0);
        chk("end_q1_empty", 64'(q1.size()), 64'd0);
        chk("end_aborts_d0", 64'(aborts0), 64'd1);
        chk("end_aborts_d1", 64'(aborts1), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
